aemb_dwb_lsu: RTL and testbench

Data-side load/store unit sitting directly downstream of the control unit. It takes the registered data-strobe, write-enable and destination-register information from control, plus the ALU effective address and store data. It runs the Wishbone data cycle with big-endian byte-lane steering, and stalls the pipeline through gena_o until the bus acknowledges. It returns aligned load data as a one-cycle register-file write.

---
 rtl/aemb_dwb_lsu.sv | 181 ++++++++++++++++++
 tb/tb_aemb_dwb_lsu.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/aemb_dwb_lsu.sv
// Data-side load/store unit: runs one Wishbone data cycle per request with
// big-endian lane steering, stalls the pipeline while busy, returns load data.
module aemb_dwb_lsu #(
    parameter int TOUT = 16
) (
    input  logic        gclk,
    input  logic        grst,
    input  logic        lsu_stb_i,
    input  logic        lsu_wre_i,
    input  logic [1:0]  lsu_siz_i,
    input  logic [31:0] lsu_adr_i,
    input  logic [31:0] lsu_dat_i,
    input  logic [4:0]  lsu_rw_i,
    output logic [29:0] dwb_adr_o,
    output logic [3:0]  dwb_sel_o,
    output logic [31:0] dwb_dat_o,
    output logic        dwb_stb_o,
    output logic        dwb_wre_o,
    input  logic [31:0] dwb_dat_i,
    input  logic        dwb_ack_i,
    output logic        gena_o,
    output logic        rf_we_o,
    output logic [4:0]  rf_wa_o,
    output logic [31:0] rf_wd_o,
    output logic        dwb_err_o,
    input  logic        err_clr_i
);
    localparam int CW = (TOUT > 1) ? $clog2(TOUT) : 1;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t         state_q, state_d;
    logic [29:0]    adr_q, adr_d;
    logic [3:0]     sel_q, sel_d;
    logic [31:0]    dat_q, dat_d;
    logic           stb_q, stb_d;
    logic           wre_q, wre_d;
    logic [1:0]     siz_q, siz_d;
    logic [1:0]     off_q, off_d;
    logic [4:0]     rw_q, rw_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           rf_we_q, rf_we_d;
    logic [4:0]     rf_wa_q, rf_wa_d;
    logic [31:0]    rf_wd_q, rf_wd_d;
    logic           err_q, err_d;
    logic [3:0]     sel_new;
    logic [31:0]    wdat_new;
    logic [31:0]    rdat_ext;
    logic           tmo;

    always_comb begin
        sel_new  = 4'b1111;
        wdat_new = lsu_dat_i;
        case (lsu_siz_i)
            2'b00: begin
                sel_new  = 4'b1000 >> lsu_adr_i[1:0];
                wdat_new = {4{lsu_dat_i[7:0]}};
            end
            2'b01: begin
                sel_new  = lsu_adr_i[1] ? 4'b0011 : 4'b1100;
                wdat_new = {2{lsu_dat_i[15:0]}};
            end
            default: ;
        endcase
    end

    // Extraction uses the size/offset captured at accept, not the live inputs.
    always_comb begin
        rdat_ext = dwb_dat_i;
        case (siz_q)
            2'b00: begin
                case (off_q)
                    2'd0:    rdat_ext = {24'd0, dwb_dat_i[31:24]};
                    2'd1:    rdat_ext = {24'd0, dwb_dat_i[23:16]};
                    2'd2:    rdat_ext = {24'd0, dwb_dat_i[15:8]};
                    default: rdat_ext = {24'd0, dwb_dat_i[7:0]};
                endcase
            end
            2'b01:   rdat_ext = off_q[1] ? {16'd0, dwb_dat_i[15:0]} : {16'd0, dwb_dat_i[31:16]};
            default: ;
        endcase
    end

    assign tmo = (TOUT != 0) && (cnt_q == CW'(TOUT - 1)) && !dwb_ack_i;

    always_comb begin
        state_d = state_q;
        adr_d   = adr_q;
        sel_d   = sel_q;
        dat_d   = dat_q;
        stb_d   = stb_q;
        wre_d   = wre_q;
        siz_d   = siz_q;
        off_d   = off_q;
        rw_d    = rw_q;
        cnt_d   = cnt_q;
        rf_we_d = 1'b0;
        rf_wa_d = rf_wa_q;
        rf_wd_d = rf_wd_q;
        err_d   = err_clr_i ? 1'b0 : err_q;
        case (state_q)
            IDLE: begin
                if (lsu_stb_i) begin
                    adr_d   = lsu_adr_i[31:2];
                    sel_d   = sel_new;
                    dat_d   = wdat_new;
                    stb_d   = 1'b1;
                    wre_d   = lsu_wre_i;
                    siz_d   = lsu_siz_i;
                    off_d   = lsu_adr_i[1:0];
                    rw_d    = lsu_rw_i;
                    cnt_d   = '0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (dwb_ack_i) begin
                    stb_d   = 1'b0;
                    wre_d   = 1'b0;
                    rf_we_d = !wre_q && (rw_q != 5'd0);
                    rf_wa_d = rw_q;
                    rf_wd_d = rdat_ext;
                    state_d = DONE;
                end else if (tmo) begin
                    stb_d   = 1'b0;
                    wre_d   = 1'b0;
                    err_d   = 1'b1;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge gclk) begin
        if (grst) begin
            state_q <= IDLE;
            adr_q   <= '0;
            sel_q   <= '0;
            dat_q   <= '0;
            stb_q   <= 1'b0;
            wre_q   <= 1'b0;
            siz_q   <= '0;
            off_q   <= '0;
            rw_q    <= '0;
            cnt_q   <= '0;
            rf_we_q <= 1'b0;
            rf_wa_q <= '0;
            rf_wd_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            adr_q   <= adr_d;
            sel_q   <= sel_d;
            dat_q   <= dat_d;
            stb_q   <= stb_d;
            wre_q   <= wre_d;
            siz_q   <= siz_d;
            off_q   <= off_d;
            rw_q    <= rw_d;
            cnt_q   <= cnt_d;
            rf_we_q <= rf_we_d;
            rf_wa_q <= rf_wa_d;
            rf_wd_q <= rf_wd_d;
            err_q   <= err_d;
        end
    end

    assign dwb_adr_o = adr_q;
    assign dwb_sel_o = sel_q;
    assign dwb_dat_o = dat_q;
    assign dwb_stb_o = stb_q;
    assign dwb_wre_o = wre_q;
    assign gena_o    = (state_q != BUSY);
    assign rf_we_o   = rf_we_q;
    assign rf_wa_o   = rf_wa_q;
    assign rf_wd_o   = rf_wd_q;
    assign dwb_err_o = err_q;
endmodule

// File: tb/tb_aemb_dwb_lsu.sv
// Directed bench for aemb_dwb_lsu (TOUT=4): inputs change and outputs are
// checked on the falling edge, half a cycle away from the active edge.
module tb_aemb_dwb_lsu;
    logic        gclk = 1'b0;
    logic        grst;
    logic        lsu_stb_i, lsu_wre_i;
    logic [1:0]  lsu_siz_i;
    logic [31:0] lsu_adr_i, lsu_dat_i;
    logic [4:0]  lsu_rw_i;
    logic [29:0] dwb_adr_o;
    logic [3:0]  dwb_sel_o;
    logic [31:0] dwb_dat_o;
    logic        dwb_stb_o, dwb_wre_o;
    logic [31:0] dwb_dat_i;
    logic        dwb_ack_i;
    logic        gena_o, rf_we_o;
    logic [4:0]  rf_wa_o;
    logic [31:0] rf_wd_o;
    logic        dwb_err_o, err_clr_i;

    int nvec = 0;
    int nerr = 0;

    aemb_dwb_lsu #(.TOUT(4)) dut (
        .gclk(gclk), .grst(grst),
        .lsu_stb_i(lsu_stb_i), .lsu_wre_i(lsu_wre_i), .lsu_siz_i(lsu_siz_i),
        .lsu_adr_i(lsu_adr_i), .lsu_dat_i(lsu_dat_i), .lsu_rw_i(lsu_rw_i),
        .dwb_adr_o(dwb_adr_o), .dwb_sel_o(dwb_sel_o), .dwb_dat_o(dwb_dat_o),
        .dwb_stb_o(dwb_stb_o), .dwb_wre_o(dwb_wre_o),
        .dwb_dat_i(dwb_dat_i), .dwb_ack_i(dwb_ack_i),
        .gena_o(gena_o), .rf_we_o(rf_we_o), .rf_wa_o(rf_wa_o), .rf_wd_o(rf_wd_o),
        .dwb_err_o(dwb_err_o), .err_clr_i(err_clr_i)
    );

    always #5 gclk = ~gclk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge gclk);
    endtask

    task automatic req(input logic wre, input logic [1:0] siz, input logic [31:0] adr,
                       input logic [31:0] dat, input logic [4:0] rw);
        lsu_stb_i = 1'b1; lsu_wre_i = wre; lsu_siz_i = siz;
        lsu_adr_i = adr;  lsu_dat_i = dat; lsu_rw_i  = rw;
        tick();
        lsu_stb_i = 1'b0;
    endtask

    initial begin
        grst = 1'b1; lsu_stb_i = 0; lsu_wre_i = 0; lsu_siz_i = 0; lsu_adr_i = 0;
        lsu_dat_i = 0; lsu_rw_i = 0; dwb_dat_i = 0; dwb_ack_i = 0; err_clr_i = 0;
        tick(); tick();
        grst = 1'b0;
        tick();
        chk("rst_stb", 32'(dwb_stb_o), 32'd0);
        chk("rst_wre", 32'(dwb_wre_o), 32'd0);
        chk("rst_rfwe", 32'(rf_we_o), 32'd0);
        chk("rst_err", 32'(dwb_err_o), 32'd0);
        chk("rst_gena", 32'(gena_o), 32'd1);
        chk("rst_adr", 32'(dwb_adr_o), 32'd0);
        chk("rst_sel", 32'(dwb_sel_o), 32'd0);
        chk("rst_dat", dwb_dat_o, 32'd0);
        chk("rst_wa", 32'(rf_wa_o), 32'd0);
        chk("rst_wd", rf_wd_o, 32'd0);

        // word load, ack in second BUSY cycle
        req(1'b0, 2'b10, 32'h0000_1004, 32'h0, 5'd5);
        chk("wl_stb", 32'(dwb_stb_o), 32'd1);
        chk("wl_adr", 32'(dwb_adr_o), 32'h401);
        chk("wl_sel", 32'(dwb_sel_o), 32'hF);
        chk("wl_wre", 32'(dwb_wre_o), 32'd0);
        chk("wl_gena1", 32'(gena_o), 32'd0);
        tick();
        chk("wl_gena2", 32'(gena_o), 32'd0);
        chk("wl_stb2", 32'(dwb_stb_o), 32'd1);
        dwb_ack_i = 1'b1; dwb_dat_i = 32'hDEADBEEF;
        tick();
        dwb_ack_i = 1'b0;
        chk("wl_rfwe", 32'(rf_we_o), 32'd1);
        chk("wl_wa", 32'(rf_wa_o), 32'd5);
        chk("wl_wd", rf_wd_o, 32'hDEADBEEF);
        chk("wl_gena_done", 32'(gena_o), 32'd1);
        chk("wl_stb_done", 32'(dwb_stb_o), 32'd0);
        tick();
        chk("wl_rfwe_idle", 32'(rf_we_o), 32'd0);

        // byte store at offset 2, immediate ack
        req(1'b1, 2'b00, 32'h0000_2002, 32'h12345678, 5'd9);
        chk("bs_sel", 32'(dwb_sel_o), 32'b0010);
        chk("bs_dat", dwb_dat_o, 32'h78787878);
        chk("bs_wre", 32'(dwb_wre_o), 32'd1);
        chk("bs_adr", 32'(dwb_adr_o), 32'h800);
        dwb_ack_i = 1'b1;
        tick();
        dwb_ack_i = 1'b0;
        chk("bs_rfwe", 32'(rf_we_o), 32'd0);
        chk("bs_wre_done", 32'(dwb_wre_o), 32'd0);
        chk("bs_stb_done", 32'(dwb_stb_o), 32'd0);
        tick();

        // half store with adr[0] set: forced aligned to upper half
        req(1'b1, 2'b01, 32'h0000_0001, 32'hCAFE5678, 5'd0);
        chk("hs_sel", 32'(dwb_sel_o), 32'b1100);
        chk("hs_dat", dwb_dat_o, 32'h56785678);
        dwb_ack_i = 1'b1;
        tick();
        dwb_ack_i = 1'b0;
        tick();

        // half load from lower half, then same with rw=0
        req(1'b0, 2'b01, 32'h0000_0002, 32'h0, 5'd3);
        chk("hl_sel", 32'(dwb_sel_o), 32'b0011);
        dwb_ack_i = 1'b1; dwb_dat_i = 32'hAABBCCDD;
        tick();
        dwb_ack_i = 1'b0;
        chk("hl_rfwe", 32'(rf_we_o), 32'd1);
        chk("hl_wa", 32'(rf_wa_o), 32'd3);
        chk("hl_wd", rf_wd_o, 32'h0000CCDD);
        tick();
        req(1'b0, 2'b01, 32'h0000_0002, 32'h0, 5'd0);
        dwb_ack_i = 1'b1;
        tick();
        dwb_ack_i = 1'b0;
        chk("hl_r0_rfwe", 32'(rf_we_o), 32'd0);
        tick();

        // byte load at offset 1
        req(1'b0, 2'b00, 32'h0000_0011, 32'h0, 5'd4);
        chk("bl_sel", 32'(dwb_sel_o), 32'b0100);
        dwb_ack_i = 1'b1;
        tick();
        dwb_ack_i = 1'b0;
        chk("bl_wd", rf_wd_o, 32'h000000BB);
        tick();

        // timeout: strobe held exactly 4 BUSY cycles
        req(1'b0, 2'b10, 32'h0000_0100, 32'h0, 5'd6);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("to_stb%0d", i), 32'(dwb_stb_o), 32'd1);
            tick();
        end
        chk("to_stb_done", 32'(dwb_stb_o), 32'd0);
        chk("to_err", 32'(dwb_err_o), 32'd1);
        chk("to_rfwe", 32'(rf_we_o), 32'd0);
        chk("to_gena", 32'(gena_o), 32'd1);
        tick();
        dwb_ack_i = 1'b1;
        tick();
        dwb_ack_i = 1'b0;
        chk("late_ack_stb", 32'(dwb_stb_o), 32'd0);
        chk("late_ack_rfwe", 32'(rf_we_o), 32'd0);
        chk("late_ack_gena", 32'(gena_o), 32'd1);
        chk("err_sticky", 32'(dwb_err_o), 32'd1);
        err_clr_i = 1'b1;
        tick();
        err_clr_i = 1'b0;
        chk("err_clr", 32'(dwb_err_o), 32'd0);

        // ack on the fourth BUSY cycle beats the timeout
        req(1'b0, 2'b10, 32'h0000_0200, 32'h0, 5'd7);
        tick(); tick(); tick();
        dwb_ack_i = 1'b1; dwb_dat_i = 32'h11223344;
        tick();
        dwb_ack_i = 1'b0;
        chk("at_rfwe", 32'(rf_we_o), 32'd1);
        chk("at_wd", rf_wd_o, 32'h11223344);
        chk("at_err", 32'(dwb_err_o), 32'd0);
        tick();

        // reset in second BUSY cycle
        req(1'b0, 2'b10, 32'h0000_0300, 32'h0, 5'd8);
        tick();
        grst = 1'b1;
        tick();
        grst = 1'b0;
        chk("gr_stb", 32'(dwb_stb_o), 32'd0);
        chk("gr_gena", 32'(gena_o), 32'd1);
        chk("gr_adr", 32'(dwb_adr_o), 32'd0);
        chk("gr_rfwe", 32'(rf_we_o), 32'd0);
        req(1'b0, 2'b10, 32'h0000_0404, 32'h0, 5'd10);
        chk("gr_req_adr", 32'(dwb_adr_o), 32'h101);
        chk("gr_req_stb", 32'(dwb_stb_o), 32'd1);
        dwb_ack_i = 1'b1; dwb_dat_i = 32'h0BADF00D;
        tick();
        dwb_ack_i = 1'b0;
        chk("gr_req_rfwe", 32'(rf_we_o), 32'd1);
        chk("gr_req_wa", 32'(rf_wa_o), 32'd10);
        chk("gr_req_wd", rf_wd_o, 32'h0BADF00D);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
